// File: rtl/data_chk_axi_mm_burst.sv
`default_nettype none
// ============================================================================
// Module : data_chk_axi_mm_burst
// Desc   : AXI4 read master that reads back a byte-ramp region in INCR bursts
//          and reports the failing-beat count and the first failing address.
// Rev    : 1.0  initial release
// ============================================================================

module data_chk_axi_mm_burst #(
  parameter int AXI_DATA_WIDTH = 32,
  parameter int AXI_ADDR_WIDTH = 32,
  parameter int MAX_BURST_LEN  = 16
) (
  input  logic                      ACLK,
  input  logic                      ARESET,
  input  logic [AXI_ADDR_WIDTH-1:0] BASE_ADDR,
  input  logic [15:0]               BYTES,
  input  logic [15:0]               REPEAT,
  input  logic                      START,
  output logic                      BUSY,
  output logic                      DONE,
  output logic [31:0]               ERR_COUNT,
  output logic [AXI_ADDR_WIDTH-1:0] FIRST_ERR_ADDR,
  output logic [AXI_ADDR_WIDTH-1:0] m_axi_araddr,
  output logic [7:0]                m_axi_arlen,
  output logic [2:0]                m_axi_arsize,
  output logic [1:0]                m_axi_arburst,
  output logic [2:0]                m_axi_arprot,
  output logic                      m_axi_arvalid,
  input  logic                      m_axi_arready,
  input  logic [AXI_DATA_WIDTH-1:0] m_axi_rdata,
  input  logic [1:0]                m_axi_rresp,
  input  logic                      m_axi_rlast,
  input  logic                      m_axi_rvalid,
  output logic                      m_axi_rready
);

  localparam int BPB = AXI_DATA_WIDTH / 8;
  localparam int SZ  = $clog2(BPB);
  localparam logic [AXI_ADDR_WIDTH-1:0] ALIGN_MASK = ~AXI_ADDR_WIDTH'(BPB - 1);
  localparam logic [AXI_ADDR_WIDTH-1:0] ADDR_STEP  = AXI_ADDR_WIDTH'(BPB);
  localparam logic [16:0]               MAX_LEN    = 17'(MAX_BURST_LEN);

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_ADDR      = 3'd1,
    S_DATA      = 3'd2,
    S_NEXT_PASS = 3'd3,
    S_FIN       = 3'd4
  } state_t;

  state_t                    state;
  logic [AXI_ADDR_WIDTH-1:0] base_addr;
  logic [AXI_ADDR_WIDTH-1:0] addr;
  logic [16:0]               pass_beats;
  logic [16:0]               beat_cnt;
  logic [15:0]               passes_left;
  logic [8:0]                burst_left;
  logic [7:0]                byte_base;

  assign m_axi_arsize  = 3'(SZ);
  assign m_axi_arburst = 2'b01;
  assign m_axi_arprot  = 3'b000;

  logic [16:0] start_beats;
  assign start_beats = {1'b0, BYTES} >> SZ;

  // Burst length: smallest of the configured maximum, the beats left in the
  // pass, and the beats that fit before the next 4 KB page.
  logic [12:0] bytes_to_4k;
  logic [16:0] remain;
  logic [16:0] to_4k;
  logic [16:0] len_beats;
  always_comb begin
    remain      = pass_beats - beat_cnt;
    bytes_to_4k = 13'h1000 - {1'b0, addr[11:0]};
    to_4k       = {4'd0, bytes_to_4k >> SZ};
    len_beats   = remain;
    if (to_4k < len_beats) len_beats = to_4k;
    if (MAX_LEN < len_beats) len_beats = MAX_LEN;
  end

  logic [BPB-1:0] byte_bad;
  for (genvar j = 0; j < BPB; j++) begin : g_byte
    assign byte_bad[j] = (m_axi_rdata[8*j +: 8] != (byte_base + 8'(j)));
  end

  logic beat_fire;
  logic final_beat;
  logic beat_bad;
  assign beat_fire  = m_axi_rvalid && m_axi_rready;
  assign final_beat = (burst_left == 9'd1);
  assign beat_bad   = (|byte_bad) || (m_axi_rresp != 2'b00) || (m_axi_rlast != final_beat);

  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      state          <= S_IDLE;
      BUSY           <= 1'b0;
      DONE           <= 1'b0;
      ERR_COUNT      <= 32'd0;
      FIRST_ERR_ADDR <= '0;
      m_axi_araddr   <= '0;
      m_axi_arlen    <= 8'd0;
      m_axi_arvalid  <= 1'b0;
      m_axi_rready   <= 1'b0;
      base_addr      <= '0;
      addr           <= '0;
      pass_beats     <= 17'd0;
      beat_cnt       <= 17'd0;
      passes_left    <= 16'd0;
      burst_left     <= 9'd0;
      byte_base      <= 8'd0;
    end else begin
      DONE <= 1'b0;
      case (state)
        S_IDLE: begin
          if (START) begin
            base_addr      <= BASE_ADDR & ALIGN_MASK;
            addr           <= BASE_ADDR & ALIGN_MASK;
            pass_beats     <= start_beats;
            beat_cnt       <= 17'd0;
            byte_base      <= 8'd0;
            passes_left    <= REPEAT;
            ERR_COUNT      <= 32'd0;
            FIRST_ERR_ADDR <= '0;
            if (start_beats == 17'd0 || REPEAT == 16'd0) begin
              state <= S_FIN;
              DONE  <= 1'b1;
            end else begin
              state <= S_ADDR;
              BUSY  <= 1'b1;
            end
          end
        end

        // First ADDR cycle loads the request; it then holds until accepted.
        S_ADDR: begin
          if (!m_axi_arvalid) begin
            m_axi_araddr  <= addr;
            m_axi_arlen   <= 8'(len_beats - 17'd1);
            burst_left    <= 9'(len_beats);
            m_axi_arvalid <= 1'b1;
          end else if (m_axi_arready) begin
            m_axi_arvalid <= 1'b0;
            m_axi_rready  <= 1'b1;
            state         <= S_DATA;
          end
        end

        S_DATA: begin
          if (beat_fire) begin
            if (beat_bad) begin
              if (ERR_COUNT != 32'hFFFF_FFFF) ERR_COUNT <= ERR_COUNT + 32'd1;
              if (ERR_COUNT == 32'd0) FIRST_ERR_ADDR <= addr;
            end
            addr       <= addr + ADDR_STEP;
            beat_cnt   <= beat_cnt + 17'd1;
            byte_base  <= byte_base + 8'(BPB);
            burst_left <= burst_left - 9'd1;
            // The beat count, not rlast, closes the burst.
            if (final_beat) begin
              m_axi_rready <= 1'b0;
              if (beat_cnt + 17'd1 < pass_beats) begin
                state <= S_ADDR;
              end else if (passes_left > 16'd1) begin
                state <= S_NEXT_PASS;
              end else begin
                state <= S_FIN;
                DONE  <= 1'b1;
                BUSY  <= 1'b0;
              end
            end
          end
        end

        S_NEXT_PASS: begin
          addr        <= base_addr;
          beat_cnt    <= 17'd0;
          byte_base   <= 8'd0;
          passes_left <= passes_left - 16'd1;
          state       <= S_ADDR;
        end

        S_FIN: begin
          state <= S_IDLE;
        end

        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_data_chk_axi_mm_burst.sv
`default_nettype none
// ============================================================================
// Module : tb_data_chk_axi_mm_burst
// Desc   : Self-checking bench: AXI read slave with stalls and fault injection,
//          expected ARs/results computed from the region/pass rules.
// Rev    : 1.0  initial release
// ============================================================================

module tb_data_chk_axi_mm_burst;

  logic        clk = 1'b0;
  logic        ARESET = 1'b1;
  logic [31:0] BASE_ADDR = 32'd0;
  logic [15:0] BYTES = 16'd0;
  logic [15:0] REPEAT = 16'd0;
  logic        START = 1'b0;
  logic        BUSY, DONE;
  logic [31:0] ERR_COUNT, FIRST_ERR_ADDR;
  logic [31:0] m_axi_araddr;
  logic [7:0]  m_axi_arlen;
  logic [2:0]  m_axi_arsize;
  logic [1:0]  m_axi_arburst;
  logic [2:0]  m_axi_arprot;
  logic        m_axi_arvalid;
  logic        m_axi_arready = 1'b0;
  logic [31:0] m_axi_rdata = 32'd0;
  logic [1:0]  m_axi_rresp = 2'b00;
  logic        m_axi_rlast = 1'b0;
  logic        m_axi_rvalid = 1'b0;
  logic        m_axi_rready;

  data_chk_axi_mm_burst #(
    .AXI_DATA_WIDTH(32),
    .AXI_ADDR_WIDTH(32),
    .MAX_BURST_LEN (16)
  ) dut (
    .ACLK          (clk),
    .ARESET        (ARESET),
    .BASE_ADDR     (BASE_ADDR),
    .BYTES         (BYTES),
    .REPEAT        (REPEAT),
    .START         (START),
    .BUSY          (BUSY),
    .DONE          (DONE),
    .ERR_COUNT     (ERR_COUNT),
    .FIRST_ERR_ADDR(FIRST_ERR_ADDR),
    .m_axi_araddr  (m_axi_araddr),
    .m_axi_arlen   (m_axi_arlen),
    .m_axi_arsize  (m_axi_arsize),
    .m_axi_arburst (m_axi_arburst),
    .m_axi_arprot  (m_axi_arprot),
    .m_axi_arvalid (m_axi_arvalid),
    .m_axi_arready (m_axi_arready),
    .m_axi_rdata   (m_axi_rdata),
    .m_axi_rresp   (m_axi_rresp),
    .m_axi_rlast   (m_axi_rlast),
    .m_axi_rvalid  (m_axi_rvalid),
    .m_axi_rready  (m_axi_rready)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] addr;
    logic [7:0]  arlen;
  } ar_t;

  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  int   last_beat_cyc = 0;
  int   gbeat = 0;
  int   r_pos = 0;
  int   cur_bpp = 1;
  bit   r_taken = 0;
  bit   stall_en = 0;
  bit   ar_pending = 0;
  logic [31:0] hold_addr;
  logic [7:0]  hold_len;
  ar_t  ar_q[$];
  ar_t  ar_log[$];
  ar_t  ar_tmp;
  bit [3:0] corrupt[int];
  bit       slverr[int];
  bit       flip[int];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Slave bookkeeping on the active edge, using pre-edge handshake values.
  always @(posedge clk) begin
    cyc++;
    ar_pending = !ARESET && m_axi_arvalid && !m_axi_arready;
    hold_addr  = m_axi_araddr;
    hold_len   = m_axi_arlen;
    if (m_axi_arvalid && m_axi_arready) begin
      ar_tmp.addr  = m_axi_araddr;
      ar_tmp.arlen = m_axi_arlen;
      ar_q.push_back(ar_tmp);
      ar_log.push_back(ar_tmp);
    end
    if (m_axi_rvalid && m_axi_rready) begin
      r_taken = 1;
      gbeat++;
      last_beat_cyc = cyc;
      if (ar_q.size() > 0) begin
        r_pos++;
        if (r_pos >= int'(ar_q[0].arlen) + 1) begin
          void'(ar_q.pop_front());
          r_pos = 0;
        end
      end
    end
    if (ARESET) begin
      ar_q.delete();
      r_pos = 0;
      r_taken = 0;
      ar_pending = 0;
    end
  end

  // Slave drive on the falling edge; also checks AR stability under backpressure.
  always @(negedge clk) begin
    if (ar_pending) begin
      chk("ar_hold_valid", m_axi_arvalid, 1);
      chk("ar_hold_addr", m_axi_araddr, hold_addr);
      chk("ar_hold_len", m_axi_arlen, hold_len);
    end
    if (ARESET) begin
      m_axi_arready = 1'b0;
      m_axi_rvalid  = 1'b0;
      m_axi_rlast   = 1'b0;
    end else begin
      m_axi_arready = stall_en ? ($urandom_range(0, 2) == 0) : 1'b1;
      if (!(m_axi_rvalid && !r_taken)) begin
        m_axi_rvalid = 1'b0;
        if (ar_q.size() > 0 && (!stall_en || $urandom_range(0, 1) == 0)) begin
          for (int j = 0; j < 4; j++) begin
            logic [7:0] b;
            b = 8'((((gbeat % cur_bpp) * 4) + j) & 255);
            if (corrupt.exists(gbeat) && corrupt[gbeat][j]) b = ~b;
            m_axi_rdata[8*j +: 8] = b;
          end
          m_axi_rresp  = slverr.exists(gbeat) ? 2'b10 : 2'b00;
          m_axi_rlast  = (r_pos == int'(ar_q[0].arlen)) ^ flip.exists(gbeat);
          m_axi_rvalid = 1'b1;
        end
      end
      r_taken = 0;
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic run(input logic [31:0] base, input int bytes, input int rep, input bit stall);
    ar_t         exp_ar[$];
    ar_t         e;
    logic [31:0] abase, a;
    int          bpp, rem, len, to4k, exp_err, done_cyc;
    logic [31:0] exp_first;
    bit          done_seen;

    // Reference: ARs from the region/4 KB/max-length rules, errors from injected faults.
    abase = base & ~32'd3;
    bpp   = bytes / 4;
    if (bpp > 0 && rep > 0) begin
      for (int p = 0; p < rep; p++) begin
        a   = abase;
        rem = bpp;
        while (rem > 0) begin
          to4k = (4096 - int'(a % 4096)) / 4;
          len  = rem;
          if (to4k < len) len = to4k;
          if (16 < len) len = 16;
          e.addr  = a;
          e.arlen = 8'(len - 1);
          exp_ar.push_back(e);
          a   = a + 32'(len * 4);
          rem = rem - len;
        end
      end
    end
    exp_err   = 0;
    exp_first = 32'd0;
    for (int g = 0; g < bpp * rep; g++) begin
      if (corrupt.exists(g) || slverr.exists(g) || flip.exists(g)) begin
        if (exp_err == 0) exp_first = abase + 32'((g % bpp) * 4);
        exp_err++;
      end
    end

    gbeat    = 0;
    cur_bpp  = (bpp > 0) ? bpp : 1;
    stall_en = stall;
    ar_log.delete();

    step();
    BASE_ADDR = base;
    BYTES     = 16'(bytes);
    REPEAT    = 16'(rep);
    START     = 1'b1;
    step();
    START = 1'b0;
    if (bpp == 0 || rep == 0) begin
      chk("deg_done", DONE, 1);
      chk("deg_arvalid", m_axi_arvalid, 0);
      step();
      chk("deg_done_pulse", DONE, 0);
      chk("deg_ar_count", ar_log.size(), 0);
      chk("deg_err", ERR_COUNT, 0);
    end else begin
      chk("busy_after_start", BUSY, 1);
      chk("arvalid_lat1", m_axi_arvalid, 0);
      step();
      chk("arvalid_lat2", m_axi_arvalid, 1);
      // A START while busy must be ignored.
      BYTES = 16'd4;
      START = 1'b1;
      step();
      START = 1'b0;
      done_seen = 0;
      done_cyc  = 0;
      for (int i = 0; i < 6000 && !done_seen; i++) begin
        if (DONE) begin
          done_seen = 1;
          done_cyc  = cyc;
        end else begin
          step();
        end
      end
      chk("done_timeout", done_seen, 1);
      if (done_seen) begin
        chk("done_latency", done_cyc, last_beat_cyc);
        chk("busy_at_done", BUSY, 0);
        step();
        chk("done_pulse", DONE, 0);
      end
      chk("err_count", ERR_COUNT, exp_err);
      chk("first_err_addr", FIRST_ERR_ADDR, exp_first);
      chk("ar_count", ar_log.size(), exp_ar.size());
      for (int i = 0; i < exp_ar.size() && i < ar_log.size(); i++) begin
        chk($sformatf("ar%0d_addr", i), ar_log[i].addr, exp_ar[i].addr);
        chk($sformatf("ar%0d_len", i), ar_log[i].arlen, exp_ar[i].arlen);
      end
    end
    corrupt.delete();
    slverr.delete();
    flip.delete();
  endtask

  task automatic chk_reset_vals();
    chk("rst_busy", BUSY, 0);
    chk("rst_done", DONE, 0);
    chk("rst_arvalid", m_axi_arvalid, 0);
    chk("rst_rready", m_axi_rready, 0);
    chk("rst_err", ERR_COUNT, 0);
    chk("rst_first", FIRST_ERR_ADDR, 0);
    chk("rst_araddr", m_axi_araddr, 0);
    chk("rst_arlen", m_axi_arlen, 0);
  endtask

  initial begin
    bit seen;
    int tot;
    repeat (3) step();
    chk_reset_vals();
    chk("arsize", m_axi_arsize, 2);
    chk("arburst", m_axi_arburst, 1);
    chk("arprot", m_axi_arprot, 0);
    ARESET = 1'b0;
    step();

    run(32'h1000, 64, 1, 0);
    run(32'h1000, 100, 3, 0);
    run(32'h0FF0, 64, 1, 0);

    corrupt[34] = 4'b0010;
    slverr[60]  = 1'b1;
    run(32'h1000, 100, 3, 0);

    corrupt[34] = 4'b0010;
    slverr[60]  = 1'b1;
    run(32'h1000, 100, 3, 1);
    run(32'h0FF0, 64, 2, 1);

    flip[3]  = 1'b1;
    flip[15] = 1'b1;
    run(32'h1002, 96, 1, 0);

    run(32'h1000, 64, 0, 0);
    run(32'h1000, 3, 2, 0);

    for (int it = 0; it < 4; it++) begin
      logic [31:0] rb;
      int rbytes, rrep;
      rb     = 32'h2000 + 32'($urandom_range(0, 16383));
      rbytes = $urandom_range(4, 300);
      rrep   = $urandom_range(1, 3);
      tot    = (rbytes / 4) * rrep;
      if ($urandom_range(0, 1) == 1) corrupt[$urandom_range(0, tot - 1)] = 4'($urandom_range(1, 15));
      if ($urandom_range(0, 1) == 1) slverr[$urandom_range(0, tot - 1)] = 1'b1;
      if ($urandom_range(0, 1) == 1) flip[$urandom_range(0, tot - 1)] = 1'b1;
      run(rb, rbytes, rrep, 1);
    end

    // Reset in the middle of a burst after an error has been recorded.
    corrupt[0] = 4'b0001;
    gbeat    = 0;
    cur_bpp  = 50;
    stall_en = 1'b0;
    BASE_ADDR = 32'h3000;
    BYTES     = 16'd200;
    REPEAT    = 16'd1;
    START     = 1'b1;
    step();
    START = 1'b0;
    seen = 0;
    for (int i = 0; i < 200 && !seen; i++) begin
      step();
      if (ERR_COUNT != 0 && m_axi_rready) seen = 1;
    end
    chk("midrst_reached", seen, 1);
    ARESET = 1'b1;
    step();
    chk_reset_vals();
    ARESET = 1'b0;
    corrupt.delete();
    step();

    run(32'h1000, 64, 1, 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
